inst_fetch: RTL and testbench

- Fetch sequencer that produces the 32-bit instruction stream consumed by the control unit's `Inst` input.
- Holds the program counter (PC) and runs a req/ack handshake with instruction memory.
- Presents each fetched word with its PC through a valid/ready output register.
- Accepts branch redirects from the datapath and squashes the wrong-path instruction.

---
 rtl/inst_fetch.sv | 158 +++++++++++++++
 tb/tb_inst_fetch.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Fetch sequencer for the control unit's instruction stream. It owns the PC,
//   runs a req/ack handshake with instruction memory and presents each fetched
//   word, together with its PC, in a single-entry valid/ready output buffer.
//   A branch redirect from the datapath squashes the wrong-path word, whether
//   that word is buffered, arriving this cycle, or still outstanding in memory.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active high
//   fetch_en       in   allow new memory requests to be issued
//   imem_req       out  request to instruction memory (FETCH/DRAIN)
//   imem_addr      out  request address (the PC register, word aligned)
//   imem_ack       in   memory accepted request, imem_rdata valid
//   imem_rdata     in   instruction word from memory
//   Inst           out  buffered instruction word
//   inst_pc        out  PC of the word on Inst
//   inst_valid     out  Inst/inst_pc valid (HAVE)
//   inst_ready     in   consumer accepts Inst this cycle
//   redirect_valid in   branch taken, restart at redirect_pc
//   redirect_pc    in   branch target (low two bits ignored)
//   busy           out  a memory request is outstanding
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         Inst,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HAVE  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q,   state_d;
  logic [PC_WIDTH-1:0] pc_q,      pc_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [PC_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]         inst_q,    inst_d;

  logic [PC_WIDTH-1:0] redir_pc;
  state_e              resume_state;

  // Branch targets are forced onto a word boundary.
  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:2], 2'b00};
  endfunction

  // Sequential PC; wraps silently modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] a);
    return a + {{(PC_WIDTH-3){1'b0}}, 3'd4};
  endfunction

  assign redir_pc     = word_align(redirect_pc);
  // Where to go once the current word or request is finished with.
  assign resume_state = fetch_en ? S_FETCH : S_IDLE;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end else if (fetch_en) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            // Returning word is wrong-path: drop it and restart at the target.
            pc_d    = redir_pc;
            state_d = resume_state;
          end else begin
            // The request cannot be withdrawn; remember the target and wait.
            pend_pc_d = redir_pc;
            state_d   = S_DRAIN;
          end
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_inc(pc_q);
          state_d   = S_HAVE;
        end
      end

      S_HAVE: begin
        // A redirect wins over a same-cycle handshake: the word is not consumed.
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = resume_state;
        end else if (inst_ready) begin
          state_d = resume_state;
        end
      end

      S_DRAIN: begin
        if (imem_ack) begin
          pc_d    = redirect_valid ? redir_pc : pend_pc_q;
          state_d = resume_state;
        end else if (redirect_valid) begin
          // Newest redirect wins.
          pend_pc_d = redir_pc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= {PC_WIDTH{1'b0}};
      inst_q    <= 32'd0;
      inst_pc_q <= {PC_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // All outputs decode directly from registered state.
  assign imem_req   = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign busy       = imem_req;
  assign inst_valid = (state_q == S_HAVE);
  assign imem_addr  = pc_q;
  assign Inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam int          PW      = 64;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic          clk;
  logic          rst;
  logic          fetch_en;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   Inst;
  logic [PW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          busy;

  logic          fetch_en2;
  logic          imem_req2;
  logic [PW-1:0] imem_addr2;
  logic          imem_ack2;
  logic [31:0]   imem_rdata2;
  logic [31:0]   Inst2;
  logic [PW-1:0] inst_pc2;
  logic          inst_valid2;
  logic          inst_ready2;
  logic          redirect_valid2;
  logic [PW-1:0] redirect_pc2;
  logic          busy2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   ack_delay = 0;
  logic force_ack = 1'b0;

  inst_fetch #(.PC_WIDTH(PW), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Inst(Inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  inst_fetch #(.PC_WIDTH(PW), .RESET_PC(WRAP_PC)) dut2 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .Inst(Inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2), .inst_ready(inst_ready2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model for dut: acks after ack_delay waiting cycles, data = addr ^ A5A5_0000.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr[31:0] ^ 32'hA5A5_0000;
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack   = force_ack;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt   = 0;
      end
    end
  end

  // Scoreboard: every accepted (non-redirected) handshake pops one expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h inst=%h want no word", inst_pc, Inst);
        end else begin
          e = exp_q.pop_front();
          if (Inst !== e.data || inst_pc !== e.pc) begin
            errors++;
            $display("FAIL sb_word: got pc=%h inst=%h want pc=%h inst=%h", inst_pc, Inst, e.pc, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = pc[31:0] ^ 32'hA5A5_0000;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1;
    tick(); tick();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got req=%b vld=%b busy=%b want 0 0 0", imem_req, inst_valid, busy);
    end
    checks++;
    if (imem_addr !== 64'd0 || Inst !== 32'd0 || inst_pc !== 64'd0) begin
      errors++; $display("FAIL reset_data: got addr=%h inst=%h pc=%h want 0", imem_addr, Inst, inst_pc);
    end
    checks++;
    if (imem_addr2 !== WRAP_PC || imem_req2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL reset_pc2: got addr=%h req=%b busy=%b want %h 0 0", imem_addr2, imem_req2, busy2, WRAP_PC);
    end
    rst = 1'b0; fetch_en = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got %b want 0", imem_req);
    end
  endtask

  task automatic test_stream();
    ack_delay = 0; inst_ready = 1'b1; fetch_en = 1'b1;
    push_exp(64'd0); push_exp(64'd4); push_exp(64'd8);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (inst_valid !== ((k % 2) == 0)) begin
        errors++; $display("FAIL stream_valid[%0d]: got %b want %b", k, inst_valid, (k % 2) == 0);
      end
      if ((k % 2) == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'((k - 1) * 2)) begin
          errors++; $display("FAIL stream_req[%0d]: got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, (k - 1) * 2);
        end
      end
    end
    fetch_en = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 64'd12) begin
      errors++; $display("FAIL stream_end: got vld=%b req=%b addr=%h want 0 0 c", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    inst_ready = 1'b0; fetch_en = 1'b1;
    push_exp(64'd12);
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || Inst !== 32'hA5A5_000C || inst_pc !== 64'd12 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: got vld=%b inst=%h pc=%h req=%b want 1 a5a5000c c 0", i, inst_valid, Inst, inst_pc, imem_req);
      end
      if (i < 5) tick();
    end
    inst_ready = 1'b1;
    push_exp(64'd16);
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'd16 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL stall_next: got req=%b addr=%h vld=%b want 1 10 0", imem_req, imem_addr, inst_valid);
    end
    tick();
    fetch_en = 1'b0;
    tick();
  endtask

  task automatic test_redirect_have();
    inst_ready = 1'b0; fetch_en = 1'b1;
    tick(); tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'd20) begin
      errors++; $display("FAIL rh_have: got vld=%b pc=%h want 1 14", inst_valid, inst_pc);
    end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h103;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
      errors++; $display("FAIL rh_target: got vld=%b req=%b addr=%h want 0 1 100", inst_valid, imem_req, imem_addr);
    end
    push_exp(64'h100);
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h100) begin
      errors++; $display("FAIL rh_word: got vld=%b pc=%h want 1 100", inst_valid, inst_pc);
    end
    fetch_en = 1'b0;
    tick();
  endtask

  task automatic test_drain();
    bit got;
    ack_delay = 3; inst_ready = 1'b1; fetch_en = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h104) begin
      errors++; $display("FAIL dr_fetch: got req=%b addr=%h want 1 104", imem_req, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h104 || busy !== 1'b1 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL dr_hold1: got req=%b addr=%h busy=%b vld=%b want 1 104 1 0", imem_req, imem_addr, busy, inst_valid);
    end
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h300;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h104 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL dr_hold2: got req=%b addr=%h vld=%b want 1 104 0", imem_req, imem_addr, inst_valid);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h300 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL dr_newest: got req=%b addr=%h vld=%b want 1 300 0", imem_req, imem_addr, inst_valid);
    end
    push_exp(64'h300);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (inst_valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || inst_pc !== 64'h300) begin
      errors++; $display("FAIL dr_return: got seen=%b pc=%h want 1 300", got, inst_pc);
    end
    fetch_en = 1'b0;
    tick();
    ack_delay = 0;
  endtask

  task automatic test_reset_drain();
    ack_delay = 3; fetch_en = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h400;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || imem_addr !== 64'h304) begin
      errors++; $display("FAIL rd_drain: got busy=%b addr=%h want 1 304", busy, imem_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 64'd0 || Inst !== 32'd0 || inst_pc !== 64'd0) begin
      errors++; $display("FAIL rd_reset: got req=%b vld=%b busy=%b addr=%h inst=%h pc=%h want all 0", imem_req, inst_valid, busy, imem_addr, Inst, inst_pc);
    end
    rst = 1'b0; fetch_en = 1'b0; force_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 64'd0) begin
        errors++; $display("FAIL rd_late_ack[%0d]: got req=%b vld=%b addr=%h want 0 0 0", i, imem_req, inst_valid, imem_addr);
      end
    end
    force_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h53;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 64'h50 || imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_redirect: got addr=%h req=%b want 50 0", imem_addr, imem_req);
    end
    ack_delay = 0;
  endtask

  task automatic test_wrap();
    checks++;
    if (imem_addr2 !== WRAP_PC) begin
      errors++; $display("FAIL wrap_idle: got %h want %h", imem_addr2, WRAP_PC);
    end
    fetch_en2 = 1'b1; inst_ready2 = 1'b0;
    tick();
    checks++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== WRAP_PC) begin
      errors++; $display("FAIL wrap_req1: got req=%b addr=%h want 1 %h", imem_req2, imem_addr2, WRAP_PC);
    end
    imem_ack2 = 1'b1; imem_rdata2 = 32'h1111_1111;
    tick();
    checks++;
    if (inst_valid2 !== 1'b1 || inst_pc2 !== WRAP_PC || Inst2 !== 32'h1111_1111 || imem_addr2 !== 64'd0) begin
      errors++; $display("FAIL wrap_word1: got vld=%b pc=%h inst=%h addr=%h want 1 %h 11111111 0", inst_valid2, inst_pc2, Inst2, imem_addr2, WRAP_PC);
    end
    imem_ack2 = 1'b0; inst_ready2 = 1'b1;
    tick();
    checks++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 64'd0) begin
      errors++; $display("FAIL wrap_req2: got req=%b addr=%h want 1 0", imem_req2, imem_addr2);
    end
    imem_ack2 = 1'b1; imem_rdata2 = 32'h2222_2222;
    tick();
    checks++;
    if (inst_valid2 !== 1'b1 || inst_pc2 !== 64'd0 || Inst2 !== 32'h2222_2222) begin
      errors++; $display("FAIL wrap_word2: got vld=%b pc=%h inst=%h want 1 0 22222222", inst_valid2, inst_pc2, Inst2);
    end
    imem_ack2 = 1'b0; fetch_en2 = 1'b0;
    tick();
    checks++;
    if (inst_valid2 !== 1'b0 || imem_addr2 !== 64'd4) begin
      errors++; $display("FAIL wrap_end: got vld=%b addr=%h want 0 4", inst_valid2, imem_addr2);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    fetch_en2 = 1'b0; imem_ack2 = 1'b0; imem_rdata2 = 32'd0;
    inst_ready2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;

    test_reset();
    test_stream();
    test_stall();
    test_redirect_have();
    test_drain();
    test_reset_drain();
    test_wrap();

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
